// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, ALU codes,
// mux selects, FSM states and the decoded instruction-class record.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b000101;
    localparam logic [5:0] OP_SLTI  = 6'b000111;
    localparam logic [5:0] OP_MOVE  = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b001001;
    localparam logic [5:0] OP_SW    = 6'b010000;
    localparam logic [5:0] OP_SB    = 6'b010001;
    localparam logic [5:0] OP_BEQ   = 6'b100011;
    localparam logic [5:0] OP_BNE   = 6'b100101;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_SLT   = 3'b011;
    localparam logic [2:0] ALU_ADD   = 3'b101;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] SRC_B_RT        = 2'd0;
    localparam logic [1:0] SRC_B_FOUR      = 2'd1;
    localparam logic [1:0] SRC_B_IMM       = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SHIFT = 2'd3;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic rtype;
        logic imm;
        logic load;
        logic store;
        logic branch_eq;
        logic branch_ne;
        logic jump;
        logic halt;
        logic illegal;
    } instr_class_t;

    // Every controller output except the debug state, so reset can clear them in one place.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_byte;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Single shared memory port: request, qualifiers, address select and ready.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic mem_byte;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_byte, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_byte, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_controller_decoder.sv
// Combinational opcode classifier: one-hot instruction class, byte-access flag
// and the ALU code used by immediate-class instructions.
module instr_class_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    output instr_class_t cls,
    output logic         byte_access,
    output logic [2:0]   imm_alu_op
);

    always_comb begin
        cls         = '0;
        byte_access = 1'b0;
        imm_alu_op  = ALU_ADD;
        unique case (opcode)
            OP_RTYPE: cls.rtype = 1'b1;
            OP_ADDI:  cls.imm   = 1'b1;
            OP_ORI: begin
                cls.imm    = 1'b1;
                imm_alu_op = ALU_OR;
            end
            OP_SLTI: begin
                cls.imm    = 1'b1;
                imm_alu_op = ALU_SLT;
            end
            OP_MOVE:  cls.imm   = 1'b1;
            OP_LW:    cls.load  = 1'b1;
            OP_LB: begin
                cls.load    = 1'b1;
                byte_access = 1'b1;
            end
            OP_SW:    cls.store = 1'b1;
            OP_SB: begin
                cls.store   = 1'b1;
                byte_access = 1'b1;
            end
            OP_BEQ:   cls.branch_eq = 1'b1;
            OP_BNE:   cls.branch_ne = 1'b1;
            OP_J:     cls.jump      = 1'b1;
            OP_HALT:  cls.halt      = 1'b1;
            default:  cls.illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB FSM driving datapath
// strobes and the single shared memory port.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [5:0]                     opcode,
    input  logic                           zero,
    multicycle_controller_if.master        mem,
    output logic                           ir_write,
    output logic                           pc_write,
    output logic [1:0]                     pc_src,
    output logic                           alu_src_a,
    output logic [1:0]                     alu_src_b,
    output logic [2:0]                     alu_op,
    output logic                           reg_write,
    output logic                           reg_dst,
    output logic                           mem_to_reg,
    output logic                           halted,
    output logic [2:0]                     state
);

    state_t       state_reg;
    state_t       state_next;
    instr_class_t cls;
    logic         byte_access;
    logic [2:0]   imm_alu_op;
    ctrl_t        ctrl;
    ctrl_t        ctrl_out;

    instr_class_decoder u_decoder (
        .opcode      (opcode),
        .cls         (cls),
        .byte_access (byte_access),
        .imm_alu_op  (imm_alu_op)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= RESET_STATE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        ctrl       = '0;
        state_next = state_reg;
        case (state_reg)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_SRC_SEQ;
                ctrl.ir_write  = mem.mem_ready;
                ctrl.pc_write  = mem.mem_ready;
                if (mem.mem_ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU forms PC + (imm << 2) here so EXEC can branch without another add.
                ctrl.alu_src_b = SRC_B_IMM_SHIFT;
                ctrl.alu_op    = ALU_ADD;
                if (cls.jump) begin
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_SRC_JUMP;
                    state_next    = S_FETCH;
                end else if (cls.halt) begin
                    state_next = S_HALT;
                end else if (cls.illegal) begin
                    state_next = S_FETCH;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                state_next     = S_FETCH;
                if (cls.rtype) begin
                    ctrl.alu_src_b = SRC_B_RT;
                    ctrl.alu_op    = ALU_FUNCT;
                    state_next     = S_WB;
                end else if (cls.imm) begin
                    ctrl.alu_src_b = SRC_B_IMM;
                    ctrl.alu_op    = imm_alu_op;
                    state_next     = S_WB;
                end else if (cls.load || cls.store) begin
                    ctrl.alu_src_b = SRC_B_IMM;
                    ctrl.alu_op    = ALU_ADD;
                    state_next     = S_MEM;
                end else if (cls.branch_eq || cls.branch_ne) begin
                    ctrl.alu_src_b = SRC_B_RT;
                    ctrl.alu_op    = ALU_SUB;
                    ctrl.pc_src    = PC_SRC_BRANCH;
                    ctrl.pc_write  = (cls.branch_eq & zero) | (cls.branch_ne & ~zero);
                end
            end
            S_MEM: begin
                ctrl.mem_req  = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.mem_we   = cls.store;
                ctrl.mem_byte = byte_access;
                if (mem.mem_ready) begin
                    state_next = cls.store ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = cls.rtype;
                ctrl.mem_to_reg = cls.load;
                state_next      = S_FETCH;
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Reset clears outputs combinationally so FETCH's request does not leak during reset.
    assign ctrl_out = reset_n ? ctrl : '0;

    assign mem.mem_req  = ctrl_out.mem_req;
    assign mem.mem_we   = ctrl_out.mem_we;
    assign mem.mem_byte = ctrl_out.mem_byte;
    assign mem.iord     = ctrl_out.iord;
    assign ir_write     = ctrl_out.ir_write;
    assign pc_write     = ctrl_out.pc_write;
    assign pc_src       = ctrl_out.pc_src;
    assign alu_src_a    = ctrl_out.alu_src_a;
    assign alu_src_b    = ctrl_out.alu_src_b;
    assign alu_op       = ctrl_out.alu_op;
    assign reg_write    = ctrl_out.reg_write;
    assign reg_dst      = ctrl_out.reg_dst;
    assign mem_to_reg   = ctrl_out.mem_to_reg;
    assign halted       = ctrl_out.halted;
    assign state        = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller: walks each instruction class
// cycle by cycle and compares strobes with hand-derived values.
module tb_multicycle_controller;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic       zero;
    logic       ir_write, pc_write, alu_src_a, reg_write, reg_dst, mem_to_reg, halted;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_op, state;
    int         checks = 0;
    int         failures = 0;

    multicycle_controller_if mem_if();

    multicycle_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem        (mem_if.master),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .halted     (halted),
        .state      (state)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] all_outs();
        return {mem_if.mem_req, mem_if.mem_we, mem_if.mem_byte, mem_if.iord, ir_write, pc_write,
                pc_src, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, halted};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        opcode = OP_RTYPE;
        zero = 1'b0;
        mem_if.mem_ready = 1'b1;
        #1;
        checks++;
        if (all_outs() !== 18'd0 || state !== 3'd0) begin
            failures++;
            $display("FAIL reset_outputs got outs=%h state=%0d expected outs=0 state=0", all_outs(), state);
        end
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || mem_if.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_held got state=%0d mem_req=%b expected 0/0", state, mem_if.mem_req);
        end
        reset_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_rtype();
        logic [2:0] exp_state [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        logic       exp_rw    [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        opcode = OP_RTYPE;
        mem_if.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (state !== exp_state[i] || reg_write !== exp_rw[i]) begin
                failures++;
                $display("FAIL rtype_c%0d got state=%0d reg_write=%b expected state=%0d reg_write=%b",
                         i, state, reg_write, exp_state[i], exp_rw[i]);
            end
            if (i == 0) begin
                checks++;
                if ({mem_if.mem_req, mem_if.iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op}
                    !== {4'b1011, 2'd0, 1'b0, 2'd1, 3'b101}) begin
                    failures++;
                    $display("FAIL rtype_fetch got req=%b iord=%b irw=%b pcw=%b pcsrc=%0d srca=%b srcb=%0d alu=%b expected 1 0 1 1 0 0 1 101",
                             mem_if.mem_req, mem_if.iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op);
                end
            end
            if (i == 2) begin
                checks++;
                if ({alu_src_a, alu_src_b, alu_op} !== {1'b1, 2'd0, 3'b111}) begin
                    failures++;
                    $display("FAIL rtype_exec got srca=%b srcb=%0d alu=%b expected 1 0 111", alu_src_a, alu_src_b, alu_op);
                end
            end
            if (i == 3) begin
                checks++;
                if (reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin
                    failures++;
                    $display("FAIL rtype_wb got reg_dst=%b mem_to_reg=%b expected 1 0", reg_dst, mem_to_reg);
                end
            end
        end
        $display("test_rtype done");
    endtask

    task automatic test_load_wait();
        opcode = OP_LW;
        mem_if.mem_ready = 1'b0;
        #1;
        checks++;
        if ({mem_if.mem_req, mem_if.iord, ir_write, pc_write, state} !== {4'b1000, 3'd0}) begin
            failures++;
            $display("FAIL fetch_wait got req=%b iord=%b irw=%b pcw=%b state=%0d expected 1 0 0 0 0",
                     mem_if.mem_req, mem_if.iord, ir_write, pc_write, state);
        end
        @(negedge clk);
        mem_if.mem_ready = 1'b1;
        #1;
        checks++;
        if ({state, mem_if.mem_req, ir_write, pc_write} !== {3'd0, 3'b111}) begin
            failures++;
            $display("FAIL fetch_ready got state=%0d req=%b irw=%b pcw=%b expected 0 1 1 1",
                     state, mem_if.mem_req, ir_write, pc_write);
        end
        @(negedge clk); #1;
        checks++;
        if (state !== 3'd1 || mem_if.mem_req !== 1'b0 || alu_src_b !== 2'd3 || alu_op !== 3'b101) begin
            failures++;
            $display("FAIL lw_decode got state=%0d req=%b srcb=%0d alu=%b expected 1 0 3 101",
                     state, mem_if.mem_req, alu_src_b, alu_op);
        end
        @(negedge clk); #1;
        checks++;
        if ({state, alu_src_a, alu_src_b, alu_op} !== {3'd2, 1'b1, 2'd2, 3'b101}) begin
            failures++;
            $display("FAIL lw_exec got state=%0d srca=%b srcb=%0d alu=%b expected 2 1 2 101",
                     state, alu_src_a, alu_src_b, alu_op);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_if.mem_ready = (k == 3);
            #1;
            checks++;
            if ({state, mem_if.mem_req, mem_if.iord, mem_if.mem_we, mem_if.mem_byte} !== {3'd3, 4'b1100}) begin
                failures++;
                $display("FAIL lw_mem%0d got state=%0d req=%b iord=%b we=%b byte=%b expected 3 1 1 0 0",
                         k, state, mem_if.mem_req, mem_if.iord, mem_if.mem_we, mem_if.mem_byte);
            end
        end
        @(negedge clk); #1;
        checks++;
        if ({state, reg_write, mem_to_reg, reg_dst, mem_if.mem_req} !== {3'd4, 4'b1100}) begin
            failures++;
            $display("FAIL lw_wb got state=%0d rw=%b m2r=%b rdst=%b req=%b expected 4 1 1 0 0",
                     state, reg_write, mem_to_reg, reg_dst, mem_if.mem_req);
        end
        @(negedge clk); #1;
        checks++;
        if (state !== 3'd0 || reg_write !== 1'b0) begin
            failures++;
            $display("FAIL lw_end got state=%0d rw=%b expected 0 0", state, reg_write);
        end
        $display("test_load_wait done");
    endtask

    task automatic test_branch();
        logic [5:0] ops  [4] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
        logic       zs   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       pcw  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        mem_if.mem_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            opcode = ops[v];
            zero = zs[v];
            @(negedge clk); #1;
            checks++;
            if (state !== 3'd1 || pc_write !== 1'b0) begin
                failures++;
                $display("FAIL br%0d_decode got state=%0d pcw=%b expected 1 0", v, state, pc_write);
            end
            @(negedge clk); #1;
            checks++;
            if ({state, pc_write, pc_src, alu_src_a, alu_src_b, alu_op} !== {3'd2, pcw[v], 2'd1, 1'b1, 2'd0, 3'b110}) begin
                failures++;
                $display("FAIL br%0d_exec got state=%0d pcw=%b pcsrc=%0d srca=%b srcb=%0d alu=%b expected 2 %b 1 1 0 110",
                         v, state, pc_write, pc_src, alu_src_a, alu_src_b, alu_op, pcw[v]);
            end
            @(negedge clk); #1;
            checks++;
            if (state !== 3'd0 || reg_write !== 1'b0) begin
                failures++;
                $display("FAIL br%0d_end got state=%0d rw=%b expected 0 0", v, state, reg_write);
            end
        end
        zero = 1'b0;
        $display("test_branch done");
    endtask

    task automatic test_imm();
        logic [5:0] ops [4] = '{OP_ADDI, OP_ORI, OP_SLTI, OP_MOVE};
        logic [2:0] alu [4] = '{3'b101, 3'b001, 3'b011, 3'b101};
        mem_if.mem_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            opcode = ops[v];
            @(negedge clk); #1;
            @(negedge clk); #1;
            checks++;
            if ({state, alu_src_a, alu_src_b, alu_op} !== {3'd2, 1'b1, 2'd2, alu[v]}) begin
                failures++;
                $display("FAIL imm%0d_exec got state=%0d srca=%b srcb=%0d alu=%b expected 2 1 2 %b",
                         v, state, alu_src_a, alu_src_b, alu_op, alu[v]);
            end
            @(negedge clk); #1;
            checks++;
            if ({state, reg_write, reg_dst, mem_to_reg} !== {3'd4, 3'b100}) begin
                failures++;
                $display("FAIL imm%0d_wb got state=%0d rw=%b rdst=%b m2r=%b expected 4 1 0 0",
                         v, state, reg_write, reg_dst, mem_to_reg);
            end
            @(negedge clk); #1;
        end
        checks++;
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL imm_end got state=%0d expected 0", state);
        end
        $display("test_imm done");
    endtask

    task automatic test_store_byte();
        logic [2:0] exp_state [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        opcode = OP_SB;
        mem_if.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (state !== exp_state[i] || reg_write !== 1'b0) begin
                failures++;
                $display("FAIL sb_c%0d got state=%0d rw=%b expected state=%0d rw=0", i, state, reg_write, exp_state[i]);
            end
            if (i == 3) begin
                checks++;
                if ({mem_if.mem_req, mem_if.iord, mem_if.mem_we, mem_if.mem_byte} !== 4'b1111) begin
                    failures++;
                    $display("FAIL sb_mem got req=%b iord=%b we=%b byte=%b expected 1 1 1 1",
                             mem_if.mem_req, mem_if.iord, mem_if.mem_we, mem_if.mem_byte);
                end
            end
        end
        $display("test_store_byte done");
    endtask

    task automatic test_jump();
        opcode = OP_J;
        mem_if.mem_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({state, pc_write, pc_src} !== {3'd1, 1'b1, 2'd2}) begin
            failures++;
            $display("FAIL j_decode got state=%0d pcw=%b pcsrc=%0d expected 1 1 2", state, pc_write, pc_src);
        end
        @(negedge clk); #1;
        checks++;
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL j_end got state=%0d expected 0", state);
        end
        $display("test_jump done");
    endtask

    task automatic test_reset_mid_mem();
        opcode = OP_LW;
        mem_if.mem_ready = 1'b1;
        @(negedge clk); #1;
        @(negedge clk);
        mem_if.mem_ready = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({state, mem_if.mem_req, mem_if.iord} !== {3'd3, 2'b11}) begin
            failures++;
            $display("FAIL rst_pre got state=%0d req=%b iord=%b expected 3 1 1", state, mem_if.mem_req, mem_if.iord);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 18'd0 || state !== 3'd0) begin
            failures++;
            $display("FAIL rst_async got outs=%h state=%0d expected 0 0", all_outs(), state);
        end
        @(negedge clk);
        reset_n = 1'b1;
        mem_if.mem_ready = 1'b1;
        opcode = 6'b110000;
        #1;
        checks++;
        if ({state, mem_if.mem_req, mem_if.iord, mem_if.mem_we} !== {3'd0, 3'b100}) begin
            failures++;
            $display("FAIL rst_refetch got state=%0d req=%b iord=%b we=%b expected 0 1 0 0",
                     state, mem_if.mem_req, mem_if.iord, mem_if.mem_we);
        end
        $display("test_reset_mid_mem done");
    endtask

    task automatic test_illegal();
        logic [2:0] exp_state [4] = '{3'd0, 3'd1, 3'd0, 3'd1};
        opcode = 6'b110000;
        mem_if.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (state !== exp_state[i] || reg_write !== 1'b0 || mem_if.mem_we !== 1'b0) begin
                failures++;
                $display("FAIL illegal_c%0d got state=%0d rw=%b we=%b expected state=%0d rw=0 we=0",
                         i, state, reg_write, mem_if.mem_we, exp_state[i]);
            end
        end
        $display("test_illegal done");
    endtask

    task automatic test_halt();
        logic [5:0] later [4] = '{6'b011111, OP_J, OP_RTYPE, OP_LW};
        opcode = OP_HALT;
        mem_if.mem_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (state !== 3'd1 || halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_decode got state=%0d halted=%b expected 1 0", state, halted);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            opcode = later[i];
            #1;
            checks++;
            if (all_outs() !== 18'd1 || state !== 3'd5) begin
                failures++;
                $display("FAIL halt_c%0d got outs=%h state=%0d expected outs=1 state=5", i, all_outs(), state);
            end
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b0 || state !== 3'd0 || mem_if.mem_req !== 1'b1) begin
            failures++;
            $display("FAIL halt_reset got halted=%b state=%0d req=%b expected 0 0 1", halted, state, mem_if.mem_req);
        end
        $display("test_halt done");
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_branch();
        test_imm();
        test_store_byte();
        test_jump();
        test_reset_mid_mem();
        test_illegal();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
